vga_line_fetch_ctrl: RTL and testbench
======================================

Name: vga_line_fetch_ctrl

Overview:
- Sequences line prefetch from a single-port frame-buffer RAM into a double-banked line buffer for the 1024x768 VGA output path.
- Driven by the hs/vs outputs of the XGA timing generator.
- Shares the frame-buffer port with the image-processor writer. Line fetch always has priority; writes are granted only when no fetch is running.

Parameters:
H_ACTIVE, 1024, pixels fetched per line
V_ACTIVE, 768, lines per frame
ADDR_W, 20, frame-buffer word address width
DATA_W, 12, pixel width (RGB444)

Ports:
clk_vga  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hs  in  1  horizontal sync from timing generator, active low
vs  in  1  vertical sync from timing generator, active low
wr_req  in  1  writer requests one pixel write
wr_addr  in  ADDR_W  writer word address
wr_data  in  DATA_W  writer pixel
wr_gnt  out  1  write accepted this cycle
mem_addr  out  ADDR_W  frame-buffer address
mem_we  out  1  frame-buffer write enable
mem_wdata  out  DATA_W  frame-buffer write data
mem_rdata  in  DATA_W  frame-buffer read data, valid 1 cycle after read address
lb_we  out  1  line-buffer write strobe
lb_addr  out  11  line-buffer column
lb_wdata  out  DATA_W  line-buffer data
lb_bank  out  1  bank being filled (row LSB)
busy  out  1  fetch in progress
overrun  out  1  sticky: line trigger arrived while busy

Behaviour:
- Reset values: state IDLE; row=0, base=0, col=0; hs_d=1, vs_d=1; lb_bank=0; all strobes, busy and overrun 0.
- Edge detect: hs_fall = hs_d & ~hs; vs_fall = vs_d & ~vs. hs_d/vs_d are registered every cycle.
- vs_fall is evaluated first, in any state:
  - row<=0, base<=0, col<=0; overrun is not set.
  - Next state FETCH (fetches row 0). A fetch already in progress is aborted; its pending lb_we is suppressed.
- hs_fall is evaluated only if vs_fall=0:
  - In IDLE with row<V_ACTIVE: col<=0, go to FETCH.
  - In IDLE with row>=V_ACTIVE: ignored.
  - In FETCH or DRAIN: overrun<=1, trigger ignored.
- FETCH:
  - Each cycle: mem_addr=base+col, mem_we=0, col++.
  - When col==H_ACTIVE-1 is issued, go to DRAIN.
- Read pipeline: a 1-cycle delayed copy of the issue drives lb_we=1, lb_addr=issued col, lb_wdata=mem_rdata. lb_bank=row[0], held for the whole fetch.
- DRAIN (1 cycle): carries the final lb_we. On exit: row++, base+=H_ACTIVE (adder, no multiplier), go to IDLE.
- busy=1 in FETCH and DRAIN.
- Total fetch time: H_ACTIVE+1 cycles (1025), which fits within a 1344-cycle line.
- Write arbitration:
  - wr_gnt = wr_req & (state==IDLE) & ~hs_fall & ~vs_fall (combinational).
  - When granted: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data. One write per cycle.
  - A denied writer holds its request.
- mem_addr=0 whenever there is neither a fetch nor a grant.
- Address arithmetic: base and mem_addr are ADDR_W bits and never wrap (row < V_ACTIVE). col is 11 bits.
- overrun is cleared only by rst_n.

Test Plan:
- Reset mid-fetch: assert rst_n=0 at col=500 -> all outputs 0 immediately; after release, no lb_we until the next hs_fall.
- Single line (H_ACTIVE=8, V_ACTIVE=4): vs_fall, memory returns data=addr -> lb_we for 8 consecutive cycles starting 2 cycles after vs_fall, lb_addr 0..7, lb_wdata 0..7, lb_bank=0; then row=1, busy=0.
- Frame sequencing: 5 hs_falls after vs_fall -> rows 1,2,3 fetched at base 8,16,24 with lb_bank 1,0,1; the 5th hs_fall (row=4) is ignored, no mem reads.
- Arbitration: wr_req held high through an hs_fall -> wr_gnt=1 before the hs_fall, 0 on the hs_fall cycle and for the next 9 cycles; writes resume in the IDLE cycle after DRAIN with mem_we=1 and mem_addr=wr_addr.
- Overrun: second hs_fall 4 cycles into a fetch -> overrun=1 and stays 1; the fetch completes unchanged.
- vs abort: vs_fall at col=3 of row 2 -> row=0, restart at base 0; no lb_we for the aborted row after the vs_fall cycle; overrun stays 0.

Source files
------------

// File: rtl/vga_line_fetch_ctrl.sv
// Line prefetch sequencer: copies one frame-buffer row per hsync into a double-banked
// line buffer, sharing the single frame-buffer port with a lower-priority pixel writer.
module vga_line_fetch_ctrl #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 12
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic              hs,
    input  logic              vs,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [10:0]       lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              lb_bank,
    output logic              busy,
    output logic              overrun
);

    localparam int                ROW_W       = $clog2(V_ACTIVE + 1);
    localparam logic [10:0]       COL_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0]  ROW_LIMIT   = ROW_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_hsD;
    logic               r_vsD;
    logic [ROW_W-1:0]   r_row;
    logic [ADDR_W-1:0]  r_base;
    logic [10:0]        r_col;
    logic               r_lbWe;
    logic [10:0]        r_lbAddr;
    logic               r_overrun;

    logic               w_hsFall;
    logic               w_vsFall;
    logic               w_startFetch;
    logic               w_setOverrun;
    logic               w_lineDone;
    logic               w_issue;
    logic               w_wrGnt;

    assign w_hsFall = r_hsD & ~hs;
    assign w_vsFall = r_vsD & ~vs;
    assign w_issue  = (r_state == FETCH);

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // vsync restarts the frame from any state; hsync only starts a line from IDLE
    always_comb begin
        w_nextState  = r_state;
        w_startFetch = 1'b0;
        w_setOverrun = 1'b0;
        w_lineDone   = 1'b0;
        case (r_state)
            FETCH: begin
                if (r_col == COL_LAST) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                w_nextState = IDLE;
                w_lineDone  = 1'b1;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (w_vsFall) begin
            w_nextState  = FETCH;
            w_startFetch = 1'b1;
            w_lineDone   = 1'b0;
        end else if (w_hsFall) begin
            if (r_state == IDLE) begin
                if (r_row < ROW_LIMIT) begin
                    w_nextState  = FETCH;
                    w_startFetch = 1'b1;
                end
            end else begin
                w_setOverrun = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_hsD     <= 1'b1;
            r_vsD     <= 1'b1;
            r_row     <= '0;
            r_base    <= '0;
            r_col     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_hsD     <= hs;
            r_vsD     <= vs;
            r_overrun <= r_overrun | w_setOverrun;
            if (w_vsFall) begin
                r_row  <= '0;
                r_base <= '0;
                r_col  <= '0;
            end else begin
                if (w_startFetch) begin
                    r_col <= '0;
                end else if (w_issue) begin
                    r_col <= r_col + 11'd1;
                end
                if (w_lineDone) begin
                    r_row  <= r_row + ROW_W'(1);
                    r_base <= r_base + LINE_STRIDE;
                end
            end
        end
    end

    // Read data arrives one cycle after the address, so the line-buffer strobe trails the issue
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_lbWe   <= 1'b0;
            r_lbAddr <= '0;
        end else begin
            r_lbWe <= w_issue & ~w_vsFall;
            if (w_issue) begin
                r_lbAddr <= r_col;
            end
        end
    end

    assign w_wrGnt = wr_req & (r_state == IDLE) & ~w_hsFall & ~w_vsFall;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_issue) begin
            mem_addr = r_base + ADDR_W'(r_col);
        end else if (w_wrGnt) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end
    end

    assign wr_gnt   = w_wrGnt;
    assign lb_we    = r_lbWe;
    assign lb_addr  = r_lbAddr;
    assign lb_wdata = r_lbWe ? mem_rdata : '0;
    assign lb_bank  = r_row[0];
    assign busy     = (r_state != IDLE);
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Scoreboard bench for vga_line_fetch_ctrl: a cycle-level line/write model predicts
// port activity and line-buffer writes, and a separate monitor pops and compares them.
module tb_vga_line_fetch_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 20;
    localparam int DW = 12;
    localparam int MW = 64;

    logic          clk_vga = 1'b0;
    logic          rst_n;
    logic          hs;
    logic          vs;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          lb_we;
    logic [10:0]   lb_addr;
    logic [DW-1:0] lb_wdata;
    logic          lb_bank;
    logic          busy;
    logic          overrun;

    vga_line_fetch_ctrl #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk_vga  (clk_vga),
        .rst_n    (rst_n),
        .hs       (hs),
        .vs       (vs),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lb_we    (lb_we),
        .lb_addr  (lb_addr),
        .lb_wdata (lb_wdata),
        .lb_bank  (lb_bank),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int            stamp;
        logic          bank;
        logic [10:0]   col;
        logic [DW-1:0] data;
    } lbExp_t;

    typedef struct {
        int            stamp;
        logic          busy;
        logic          ovr;
        logic          gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } stExp_t;

    lbExp_t        lbQ[$];
    stExp_t        stQ[$];
    logic [DW-1:0] initMem[MW];
    logic [DW-1:0] envMem[MW];
    logic [DW-1:0] refMem[MW];
    logic          memLoad = 1'b1;
    bit            running = 1'b1;
    int            compared = 0;
    int            mismatched = 0;
    int            cycle = 0;

    bit mHsD = 1'b1;
    bit mVsD = 1'b1;
    bit mOvr = 1'b0;
    int mRow = 0;
    int tTrig = -100;
    int fetchBase = 0;
    bit wrEnable = 1'b1;
    bit reqHeld = 1'b0;

    // Frame-buffer RAM with one-cycle read latency
    always @(posedge clk_vga) begin
        if (memLoad) begin
            for (int i = 0; i < MW; i++) envMem[i] <= initMem[i];
        end else begin
            if (mem_we) envMem[mem_addr[5:0]] <= mem_wdata;
            mem_rdata <= envMem[mem_addr[5:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic startLine(input int k, input int r);
        lbExp_t e;
        for (int c = 0; c < H; c++) begin
            e.stamp = k + 2 + c;
            e.bank  = 1'(r % 2);
            e.col   = 11'(c);
            e.data  = refMem[r * H + c];
            lbQ.push_back(e);
        end
        tTrig     = k;
        fetchBase = r * H;
        mRow      = r + 1;
    endtask

    task automatic applyStimulus(input logic nHs, input logic nVs);
        bit     hsFall, vsFall, busyNow, inFetch, gnt;
        stExp_t st;
        int     k;
        @(negedge clk_vga);
        memLoad = 1'b0;
        cycle++;
        k = cycle;
        rst_n = 1'b1;
        hs = nHs;
        vs = nVs;
        if (!reqHeld) begin
            if (wrEnable && $urandom_range(1, 0) == 1) begin
                wr_req  = 1'b1;
                wr_addr = AW'($urandom_range(H * V - 1, 0));
                wr_data = DW'($urandom);
            end else begin
                wr_req = 1'b0;
            end
        end
        hsFall  = mHsD & ~nHs;
        vsFall  = mVsD & ~nVs;
        busyNow = (k > tTrig) && (k <= tTrig + H + 1);
        inFetch = (k > tTrig) && (k <= tTrig + H);
        gnt     = wr_req & ~busyNow & ~hsFall & ~vsFall;
        reqHeld = wr_req & ~gnt;
        st.stamp = k;
        st.busy  = busyNow;
        st.ovr   = mOvr;
        st.gnt   = gnt;
        st.we    = gnt;
        st.addr  = inFetch ? AW'(fetchBase + (k - tTrig - 1)) : (gnt ? wr_addr : '0);
        st.wdata = gnt ? wr_data : '0;
        stQ.push_back(st);
        if (gnt) refMem[wr_addr[5:0]] = wr_data;
        if (vsFall) begin
            while (lbQ.size() > 0 && lbQ[$].stamp > k) void'(lbQ.pop_back());
            startLine(k, 0);
        end else if (hsFall) begin
            if (busyNow) mOvr = 1'b1;
            else if (mRow < V) startLine(k, mRow);
        end
        mHsD = nHs;
        mVsD = nVs;
    endtask

    task automatic doReset(input int n);
        stExp_t st;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_vga);
            memLoad = 1'b0;
            cycle++;
            rst_n   = 1'b0;
            hs      = 1'b1;
            vs      = 1'b1;
            wr_req  = 1'b0;
            reqHeld = 1'b0;
            while (lbQ.size() > 0 && lbQ[$].stamp >= cycle) void'(lbQ.pop_back());
            tTrig = -100;
            mRow  = 0;
            mOvr  = 1'b0;
            mHsD  = 1'b1;
            mVsD  = 1'b1;
            st.stamp = cycle;
            st.busy  = 1'b0;
            st.ovr   = 1'b0;
            st.gnt   = 1'b0;
            st.we    = 1'b0;
            st.addr  = '0;
            st.wdata = '0;
            stQ.push_back(st);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1);
    endtask

    task automatic randomPhase(input int n);
        int hsLow = 0;
        int vsLow = 0;
        for (int i = 0; i < n; i++) begin
            if (hsLow > 0) hsLow--;
            else if ($urandom_range(9, 0) == 0) hsLow = $urandom_range(3, 1);
            if (vsLow > 0) vsLow--;
            else if ($urandom_range(149, 0) == 0) vsLow = $urandom_range(4, 1);
            applyStimulus(logic'(hsLow == 0), logic'(vsLow == 0));
        end
    endtask

    // Monitor: compares every cycle's port activity and any line-buffer write
    initial begin
        stExp_t st;
        lbExp_t e;
        bit     expWe;
        forever begin
            @(negedge clk_vga);
            #2;
            if (running) begin
                if (stQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL status_queue cycle %0d: got empty expected entry", cycle);
                end else begin
                    st = stQ.pop_front();
                    checkOutput("busy", 32'(busy), 32'(st.busy));
                    checkOutput("overrun", 32'(overrun), 32'(st.ovr));
                    checkOutput("wr_gnt", 32'(wr_gnt), 32'(st.gnt));
                    checkOutput("mem_we", 32'(mem_we), 32'(st.we));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(st.addr));
                    checkOutput("mem_wdata", 32'(mem_wdata), 32'(st.wdata));
                end
                while (lbQ.size() > 0 && lbQ[0].stamp < cycle) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL lb_stale cycle %0d: got none expected write at cycle %0d", cycle, lbQ[0].stamp);
                    void'(lbQ.pop_front());
                end
                expWe = (lbQ.size() > 0) && (lbQ[0].stamp == cycle);
                checkOutput("lb_we", 32'(lb_we), 32'(expWe));
                if (expWe) begin
                    e = lbQ.pop_front();
                    if (lb_we === 1'b1) begin
                        checkOutput("lb_bank", 32'(lb_bank), 32'(e.bank));
                        checkOutput("lb_addr", 32'(lb_addr), 32'(e.col));
                        checkOutput("lb_wdata", 32'(lb_wdata), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        hs      = 1'b1;
        vs      = 1'b1;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < MW; i++) begin
            initMem[i] = DW'($urandom);
            refMem[i]  = initMem[i];
        end
        doReset(3);
        idle(2);

        $display("[TB] frame sequencing");
        applyStimulus(1'b1, 1'b0);
        idle(H + 4);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b0, 1'b1);
            idle(H + 4);
        end

        $display("[TB] vsync abort mid-line");
        applyStimulus(1'b1, 1'b0);
        idle(H + 4);
        applyStimulus(1'b0, 1'b1);
        idle(H + 4);
        applyStimulus(1'b0, 1'b1);
        idle(3);
        applyStimulus(1'b1, 1'b0);
        idle(H + 4);

        $display("[TB] overrun");
        applyStimulus(1'b0, 1'b1);
        idle(4);
        applyStimulus(1'b0, 1'b1);
        idle(H + 4);

        $display("[TB] reset mid-fetch");
        applyStimulus(1'b0, 1'b1);
        idle(5);
        doReset(2);
        idle(4);
        applyStimulus(1'b1, 1'b0);
        idle(H + 4);

        $display("[TB] random traffic");
        randomPhase(1500);
        doReset(2);
        randomPhase(1500);
        idle(H + 4);

        #4;
        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
